// File: rtl/imem_prog_loader.sv
// Streams a little-endian program image (addr, count, words, checksum) into the
// core's instruction memory debug port, holding the core in reset until verified.
module imem_prog_loader #(
    parameter int XLEN      = 32,
    parameter int MAX_WORDS = 1024,
    parameter int RST_HOLD  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            s_valid,
    input  logic [7:0]      s_data,
    output logic            s_ready,
    output logic            dbg_wr_en,
    output logic [XLEN-1:0] dbg_addr,
    output logic [XLEN-1:0] dbg_instr,
    output logic            core_rst,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [1:0]      err_code,
    output logic [3:0]      fsm_state
);
    localparam int HOLD_LD = (RST_HOLD < 1) ? 1 : RST_HOLD;
    localparam int HW      = $clog2(HOLD_LD + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_COUNT, S_DATA, S_WRITE, S_CSUM, S_HOLD, S_DONE, S_ERROR
    } state_t;

    // Handshake: a byte moves on a rising edge where s_valid && s_ready; s_ready
    // is a registered function of state, so a held s_valid simply waits.
    state_t            state;
    logic [1:0]        idx;
    logic [31:0]       asm_reg;
    logic [XLEN-1:0]   addr_reg;
    logic [31:0]       count_reg;
    logic [31:0]       word_cnt;
    logic [XLEN-1:0]   csum_acc;
    logic [HW-1:0]     hold_cnt;
    logic              byte_fire;
    logic [31:0]       word_full;

    assign byte_fire = s_valid && s_ready;
    assign word_full = {s_data, asm_reg[23:0]};
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= 2'd0;
            asm_reg   <= '0;
            addr_reg  <= '0;
            count_reg <= '0;
            word_cnt  <= '0;
            csum_acc  <= '0;
            hold_cnt  <= '0;
            s_ready   <= 1'b0;
            dbg_wr_en <= 1'b0;
            dbg_addr  <= '0;
            dbg_instr <= '0;
            core_rst  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            dbg_wr_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state    <= S_ADDR;
                        s_ready  <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        err_code <= 2'd0;
                        core_rst <= 1'b1;
                        idx      <= 2'd0;
                        word_cnt <= '0;
                        csum_acc <= '0;
                    end
                end
                S_ADDR, S_COUNT, S_DATA, S_CSUM: begin
                    if (byte_fire) begin
                        asm_reg[idx*8 +: 8] <= s_data;
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            case (state)
                                S_ADDR: begin
                                    if (word_full[1:0] != 2'd0) begin
                                        state    <= S_ERROR;
                                        s_ready  <= 1'b0;
                                        busy     <= 1'b0;
                                        error    <= 1'b1;
                                        err_code <= 2'd1;
                                    end else begin
                                        addr_reg <= XLEN'(word_full);
                                        state    <= S_COUNT;
                                    end
                                end
                                S_COUNT: begin
                                    count_reg <= word_full;
                                    if (word_full > 32'(MAX_WORDS)) begin
                                        state    <= S_ERROR;
                                        s_ready  <= 1'b0;
                                        busy     <= 1'b0;
                                        error    <= 1'b1;
                                        err_code <= 2'd2;
                                    end else if (word_full == 32'd0) begin
                                        state <= S_CSUM;
                                    end else begin
                                        state <= S_DATA;
                                    end
                                end
                                S_DATA: begin
                                    // The write strobe is registered here so it lands the cycle after byte 4.
                                    state     <= S_WRITE;
                                    s_ready   <= 1'b0;
                                    dbg_wr_en <= 1'b1;
                                    dbg_addr  <= addr_reg;
                                    dbg_instr <= XLEN'(word_full);
                                end
                                default: begin
                                    s_ready <= 1'b0;
                                    if (XLEN'(word_full) == csum_acc) begin
                                        state    <= S_HOLD;
                                        hold_cnt <= HW'(HOLD_LD);
                                    end else begin
                                        state    <= S_ERROR;
                                        busy     <= 1'b0;
                                        error    <= 1'b1;
                                        err_code <= 2'd3;
                                    end
                                end
                            endcase
                        end
                    end
                end
                S_WRITE: begin
                    csum_acc <= csum_acc + dbg_instr;
                    addr_reg <= addr_reg + XLEN'(4);
                    word_cnt <= word_cnt + 32'd1;
                    s_ready  <= 1'b1;
                    state    <= (word_cnt + 32'd1 == count_reg) ? S_CSUM : S_DATA;
                end
                S_HOLD: begin
                    if (hold_cnt <= HW'(1)) begin
                        state    <= S_DONE;
                        core_rst <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_prog_loader.sv
// Scenario bench for imem_prog_loader: byte-stream driver, write scoreboard, summary.
module tb_imem_prog_loader;
    localparam int RST_HOLD  = 4;
    localparam int MAX_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready, dbg_wr_en, core_rst, busy, done, error;
    logic [31:0] dbg_addr, dbg_instr;
    logic [1:0]  err_code;
    logic [3:0]  fsm_state;

    int          total = 0;
    int          bad = 0;
    int          writes = 0;
    logic [63:0] exp_q[$];
    logic [31:0] img_q[$];
    logic [63:0] mon_e;

    imem_prog_loader #(.XLEN(32), .MAX_WORDS(MAX_WORDS), .RST_HOLD(RST_HOLD)) dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .dbg_wr_en(dbg_wr_en), .dbg_addr(dbg_addr),
        .dbg_instr(dbg_instr), .core_rst(core_rst), .busy(busy), .done(done),
        .error(error), .err_code(err_code), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // Scoreboard: every write strobe must match the oldest expected {addr, word}.
    always @(negedge clk) begin
        if (dbg_wr_en === 1'b1) begin
            writes++;
            total++;
            if (s_ready !== 1'b0) begin
                bad++;
                $display("FAIL wr_ready: s_ready=%b required 0", s_ready);
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected: addr=%h instr=%h required no write", dbg_addr, dbg_instr);
            end else begin
                mon_e = exp_q.pop_front();
                if ({dbg_addr, dbg_instr} !== mon_e)
                begin
                    bad++;
                    $display("FAIL wr_data: got %h/%h required %h/%h",
                             dbg_addr, dbg_instr, mon_e[63:32], mon_e[31:0]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        n = 0;
        while (s_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL byte_timeout: waited %0d cycles required <100", n);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], $urandom_range(0, max_gap));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_image(input logic [31:0] addr, input logic [31:0] count,
                              input logic [31:0] csum, input int max_gap, input bit start_mid);
        logic [31:0] a;
        pulse_start();
        send_word(addr, max_gap);
        send_word(count, max_gap);
        a = addr;
        for (int i = 0; i < img_q.size(); i++) begin
            exp_q.push_back({a, img_q[i]});
            send_word(img_q[i], max_gap);
            a = a + 32'd4;
            if (start_mid && i == 0) pulse_start();
        end
        send_word(csum, max_gap);
    endtask

    task automatic wait_end();
        int cyc;
        cyc = 0;
        while (done !== 1'b1 && error !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc >= 200) begin
            bad++;
            $display("FAIL end_timeout: waited %0d cycles required <200", cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({dbg_wr_en, core_rst, s_ready, busy, done, error, err_code} !== 8'b0100_0000) begin
            bad++;
            $display("FAIL reset_flags: got %b required 01000000",
                     {dbg_wr_en, core_rst, s_ready, busy, done, error, err_code});
        end
        total++;
        if ({dbg_addr, dbg_instr, fsm_state} !== 68'd0) begin
            bad++;
            $display("FAIL reset_regs: addr=%h instr=%h state=%0d required 0", dbg_addr, dbg_instr, fsm_state);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int n;
        writes = 0;
        img_q = '{32'h00500093, 32'h00A00113};
        load_image(32'h0, 32'd2, 32'h00F001A6, 0, 1'b0);
        total++;
        if (core_rst !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_hold: core_rst=%b busy=%b required 1/1", core_rst, busy);
        end
        n = 0;
        while (core_rst === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n != RST_HOLD) begin
            bad++;
            $display("FAIL basic_hold_len: got %0d required %0d", n, RST_HOLD);
        end
        total++;
        if ({done, error, busy} !== 3'b100 || writes != 2 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL basic_end: done/error/busy=%b writes=%0d pend=%0d required 100/2/0",
                     {done, error, busy}, writes, exp_q.size());
        end
    endtask

    task automatic test_misaligned();
        writes = 0;
        pulse_start();
        send_word(32'h00000002, 0);
        total++;
        if ({error, err_code, core_rst, busy} !== 5'b10110 || writes != 0) begin
            bad++;
            $display("FAIL misalign: error/code/core_rst/busy=%b writes=%0d required 10110/0",
                     {error, err_code, core_rst, busy}, writes);
        end
        img_q = '{32'h12345678};
        load_image(32'h100, 32'd1, 32'h12345678, 1, 1'b0);
        wait_end();
        total++;
        if ({done, error, err_code} !== 4'b1000 || writes != 1) begin
            bad++;
            $display("FAIL misalign_recover: done/error/code=%b writes=%0d required 1000/1",
                     {done, error, err_code}, writes);
        end
    endtask

    task automatic test_count_limits();
        writes = 0;
        pulse_start();
        send_word(32'h0, 0);
        send_word(32'h00000401, 0);
        total++;
        if ({error, err_code, core_rst} !== 4'b1101) begin
            bad++;
            $display("FAIL count_over: error/code/core_rst=%b required 1101", {error, err_code, core_rst});
        end
        pulse_start();
        send_word(32'h0, 0);
        send_word(32'(MAX_WORDS), 0);
        total++;
        if (fsm_state !== 4'd3 || error !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL count_max: state=%0d error=%b busy=%b required 3/0/1", fsm_state, error, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        img_q.delete();
        load_image(32'h40, 32'd0, 32'd0, 0, 1'b0);
        wait_end();
        total++;
        if ({done, error, core_rst} !== 3'b100 || writes != 0) begin
            bad++;
            $display("FAIL count_zero: done/error/core_rst=%b writes=%0d required 100/0",
                     {done, error, core_rst}, writes);
        end
    endtask

    task automatic test_bad_csum();
        writes = 0;
        img_q = '{32'h00000013};
        load_image(32'h0, 32'd1, 32'h00000014, 0, 1'b0);
        total++;
        if ({error, err_code, core_rst, done} !== 5'b11110 || writes != 1) begin
            bad++;
            $display("FAIL bad_csum: error/code/core_rst/done=%b writes=%0d required 11110/1",
                     {error, err_code, core_rst, done}, writes);
        end
    endtask

    task automatic test_random_gaps();
        logic [31:0] sum;
        writes = 0;
        sum = 32'd0;
        img_q.delete();
        for (int i = 0; i < 6; i++) begin
            img_q.push_back($urandom());
            sum = sum + img_q[i];
        end
        load_image($urandom() & 32'hFFFF_FFFC, 32'd6, sum, 3, 1'b1);
        wait_end();
        total++;
        if ({done, error} !== 2'b10 || writes != 6 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL random_gaps: done/error=%b writes=%0d pend=%0d required 10/6/0",
                     {done, error}, writes, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] sum;
        writes = 0;
        sum = 32'd0;
        img_q.delete();
        for (int i = 0; i < 3; i++) begin
            img_q.push_back($urandom() | 32'h8000_0000);
            sum = sum + img_q[i];
        end
        load_image(32'hFFFF_FFF8, 32'd3, sum, 0, 1'b0);
        wait_end();
        total++;
        if ({done, error, core_rst} !== 3'b100 || writes != 3 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL back_to_back: done/error/core_rst=%b writes=%0d pend=%0d required 100/3/0",
                     {done, error, core_rst}, writes, exp_q.size());
        end
    endtask

    task automatic test_rst_mid();
        writes = 0;
        pulse_start();
        send_word(32'h0, 0);
        send_word(32'd1, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({dbg_wr_en, core_rst, s_ready, busy, done, error, err_code} !== 8'b0100_0000 ||
            {dbg_addr, dbg_instr, fsm_state} !== 68'd0) begin
            bad++;
            $display("FAIL rst_mid: flags=%b addr=%h instr=%h state=%0d required 01000000/0/0/0",
                     {dbg_wr_en, core_rst, s_ready, busy, done, error, err_code},
                     dbg_addr, dbg_instr, fsm_state);
        end
        rst = 1'b0;
        @(negedge clk);
        img_q = '{32'hCAFE_F00D};
        load_image(32'h20, 32'd1, 32'hCAFE_F00D, 0, 1'b0);
        wait_end();
        total++;
        if ({done, error} !== 2'b10 || writes != 1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL rst_fresh: done/error=%b writes=%0d pend=%0d required 10/1/0",
                     {done, error}, writes, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_misaligned();
        test_count_limits();
        test_bad_csum();
        test_random_gaps();
        test_back_to_back();
        test_rst_mid();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
